dma_stream_engine: RTL and testbench

//  Parametrised successor of the single-mode DMA test-pattern controller: AXI-Stream packet engine with ingress FIFO.

---
 rtl/dma_stream_engine.sv | 194 +++++++++++++++++++
 tb/tb_dma_stream_engine.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_engine.sv
// rtl/dma_stream_engine.sv - AXI-Stream packet engine: counter-pattern generator and ingress-FIFO loopback
// Optional feature macro: DMA_STATS_EN adds saturating stat_pkts / stat_beats counters.
module dma_stream_engine #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [LEN_W-1:0]    pkt_len,
  output logic                busy,
  output logic                done,
  output logic                trunc,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready
`ifdef DMA_STATS_EN
  ,
  output logic [31:0]         stat_pkts,
  output logic [31:0]         stat_beats
`endif
);

  localparam int KW = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + KW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic              start_q;
  logic              mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_idx;
  logic [15:0]       pkt_seq;
  logic              trunc_pend;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_next;
  logic [PW-1:0]     rd_next;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_data;
  logic [KW-1:0]     head_keep;
  logic              head_last;

  logic              launch;
  logic              hs;
  logic              out_free;
  logic              last_idx;
  logic [DATA_W-1:0] gen_data;

  // FIFO status, launch edge detect, output-slot availability and next gen-mode beat
  always_comb begin
    push       = s_tvalid & s_tready;
    fifo_empty = (wr_ptr == rd_ptr);
    {head_data, head_keep, head_last} = fifo_mem[rd_ptr[AW-1:0]];
    launch     = (state == IDLE) & start & ~start_q;
    hs         = m_tvalid & m_tready;
    // Output register may take a new beat when empty or draining a non-final beat
    out_free   = ~m_tvalid | (m_tready & ~m_tlast);
    pop        = (state == RUN) & mode_q & out_free & ~fifo_empty;
    wr_next    = wr_ptr + PW'(push);
    rd_next    = rd_ptr + PW'(pop);
    last_idx   = (beat_idx == len_q - LEN_W'(1));
    gen_data   = '0;
    gen_data[15:0]  = 16'(beat_idx);
    gen_data[31:16] = pkt_seq;
  end

  // Ingress FIFO storage; entries are not reset, validity comes from the pointers
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast};
    end
  end

  // FIFO pointers; s_tready is registered from the post-edge fill level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      s_tready <= 1'b0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      s_tready <= ((wr_next - rd_next) != PW'(FIFO_DEPTH));
    end
  end

  // Packet FSM with registered egress stage and status pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      beat_idx   <= '0;
      pkt_seq    <= '0;
      trunc_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trunc      <= 1'b0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tvalid   <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      trunc   <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            mode_q     <= mode;
            len_q      <= pkt_len;
            beat_idx   <= '0;
            trunc_pend <= 1'b0;
            busy       <= 1'b1;
            if (pkt_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (hs & m_tlast) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            state    <= DONE;
            done     <= 1'b1;
            trunc    <= trunc_pend;
          end else if (out_free) begin
            if (!mode_q) begin
              m_tdata  <= gen_data;
              m_tkeep  <= '1;
              m_tlast  <= last_idx;
              m_tvalid <= 1'b1;
              beat_idx <= beat_idx + LEN_W'(1);
            end else if (pop) begin
              m_tdata    <= head_data;
              m_tkeep    <= head_keep;
              m_tlast    <= head_last | last_idx;
              m_tvalid   <= 1'b1;
              trunc_pend <= last_idx & ~head_last;
              beat_idx   <= beat_idx + LEN_W'(1);
            end else begin
              m_tvalid <= 1'b0;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pkt_seq <= pkt_seq + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_STATS_EN
  // Saturating completed-packet and egress-beat counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_pkts  <= '0;
      stat_beats <= '0;
    end else begin
      if ((state == DONE) && (stat_pkts != '1)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (hs && (stat_beats != '1)) begin
        stat_beats <= stat_beats + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_stream_engine.sv
// tb/tb_dma_stream_engine.sv - self-checking bench for dma_stream_engine
`timescale 1ns/1ps
module tb_dma_stream_engine;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic          busy, done, trunc;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast, m_tvalid;
  logic          m_tready = 1'b1;
`ifdef DMA_STATS_EN
  logic [31:0]   stat_pkts, stat_beats;
`endif

  dma_stream_engine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .pkt_len(pkt_len),
    .busy(busy), .done(done), .trunc(trunc),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef DMA_STATS_EN
    , .stat_pkts(stat_pkts), .stat_beats(stat_beats)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       fifo_m[$];
  logic [31:0] log_q[$];
  beat_t       mon_b;
  logic [15:0] seq_m = '0;
  logic        trunc_m = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_edge = 0;
  int   last_hs_edge = 0;
  int   hs_cnt = 0;
  logic trunc_seen = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_d;
  logic [KW-1:0] prev_k;
  logic          prev_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc = cyc + 1;

  // Compare process: every egress handshake against the model queue, plus hold-while-stalled
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_d);
        check("hold_keep", m_tkeep, prev_k);
        check("hold_last", m_tlast, prev_l);
      end
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        log_q.push_back(m_tdata);
        if (m_tlast) last_hs_edge = cyc + 1;
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_b = exp_q.pop_front();
          check("tdata", m_tdata, mon_b.d);
          check("tkeep", m_tkeep, mon_b.keep);
          check("tlast", m_tlast, mon_b.last);
        end
      end
      if (done) begin
        done_cnt++;
        done_edge  = cyc;
        trunc_seen = trunc;
      end else begin
        check("trunc_without_done", trunc, 0);
      end
      stall_prev = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_k = m_tkeep;
      prev_l = m_tlast;
    end
  end

  task automatic push_beat(input logic [31:0] d, input logic [3:0] keep, input logic l, output logic acc);
    beat_t b;
    s_tdata  = d;
    s_tkeep  = keep;
    s_tlast  = l;
    s_tvalid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(negedge clock);
      if (s_tready) begin
        acc = 1'b1;
        b.d = d; b.keep = keep; b.last = l;
        fifo_m.push_back(b);
      end
      @(posedge clock); #1;
    end
    s_tvalid = 1'b0;
  endtask

  // Builds the expected packet from the rules, launches it and waits for done
  task automatic launch(input logic md, input int len, input logic hold, input logic stall);
    int    d0;
    int    k;
    logic  got;
    logic  fin;
    beat_t b;
    trunc_m = 1'b0;
    log_q.delete();
    if (!md) begin
      for (k = 0; k < len; k++) begin
        b.d = {seq_m, 16'(k)}; b.keep = 4'hF; b.last = (k == len - 1);
        exp_q.push_back(b);
      end
    end else begin
      k = 0;
      fin = 1'b0;
      while (k < len && fifo_m.size() > 0 && !fin) begin
        b = fifo_m.pop_front();
        if (k == len - 1 && !b.last) begin
          trunc_m = 1'b1;
          b.last  = 1'b1;
        end
        exp_q.push_back(b);
        k++;
        fin = b.last;
      end
    end
    d0 = done_cnt;
    mode = md;
    pkt_len = LW'(len);
    start = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= 400 && !got; i++) begin
      @(posedge clock); #1;
      if (stall) m_tready = ~m_tready;
      if (i == 1) begin
        check("busy_after_launch", busy, 1);
        check("no_valid_at_launch", m_tvalid, 0);
      end
      if (i == 2 && !md && len > 0) check("gen_first_valid", m_tvalid, 1);
      if (done_cnt != d0) got = 1'b1;
    end
    check("done_seen", got, 1);
    check("done_width", done, 0);
    check("idle_after_done", busy, 0);
    if (len > 0) check("done_after_tlast", done_edge - last_hs_edge, 0);
    check("trunc", trunc_seen, trunc_m);
    check("all_beats_sent", exp_q.size(), 0);
    exp_q.delete();
    seq_m = seq_m + 16'd1;
    m_tready = 1'b1;
    if (!hold) start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("single_done", done_cnt - d0, 1);
  endtask

  initial begin
    logic  acc;
    int    acc_cnt;
    int    h0;
    int    d0;
    int    busy_seen;
    beat_t b;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trunc", trunc, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_tready", s_tready, 0);
    reset = 1'b0;
    check("tready_before_edge", s_tready, 0);
    @(posedge clock); #1;
    check("tready_after_release", s_tready, 1);
    repeat (2) @(posedge clock);
    #1;

    // 1: gen len 4
    launch(1'b0, 4, 1'b0, 1'b0);
    check("t1_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t1_beat0", log_q[0], 32'h0000_0000);
      check("t1_beat3", log_q[3], 32'h0000_0003);
    end

    // 2: gen len 8 with back-pressure, second packet
    launch(1'b0, 8, 1'b0, 1'b1);
    check("t2_beats", log_q.size(), 8);
    if (log_q.size() == 8) begin
      check("t2_beat0", log_q[0], 32'h0001_0000);
      check("t2_beat7", log_q[7], 32'h0001_0007);
    end

    // 3: loopback ending on stored tlast
    push_beat(32'hA0, 4'hF, 1'b0, acc);
    push_beat(32'hA1, 4'h3, 1'b0, acc);
    push_beat(32'hA2, 4'h1, 1'b1, acc);
    launch(1'b1, 16, 1'b0, 1'b0);
    check("t3_beats", log_q.size(), 3);
    if (log_q.size() == 3) check("t3_beat2", log_q[2], 32'hA2);
    check("t3_trunc", trunc_seen, 0);

    // 4: loopback truncated by length, remainder stays queued
    for (int i = 0; i < 5; i++) push_beat(32'hB0 + i, 4'hF, 1'b0, acc);
    launch(1'b1, 2, 1'b0, 1'b0);
    check("t4_beats", log_q.size(), 2);
    if (log_q.size() == 2) check("t4_beat1", log_q[1], 32'hB1);
    check("t4_trunc", trunc_seen, 1);
    check("t4_remaining", fifo_m.size(), 3);
    launch(1'b1, 3, 1'b0, 1'b0);
    check("t4_drain_beats", log_q.size(), 3);
    if (log_q.size() == 3) check("t4_drain_first", log_q[0], 32'hB2);

    // 5: fill FIFO with 17 attempts, 16 accepted
    acc_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      push_beat(32'hC00 + i, 4'hF, 1'b0, acc);
      if (acc) acc_cnt++;
    end
    check("t5_accepted", acc_cnt, 16);
    repeat (3) @(posedge clock);
    #1;
    check("t5_full_ready", s_tready, 0);
    launch(1'b1, 16, 1'b0, 1'b0);
    check("t5_drain_beats", log_q.size(), 16);
    if (log_q.size() == 16) check("t5_last", log_q[15], 32'hC0F);
    check("t5_drain_trunc", trunc_seen, 1);
    check("t5_ready_again", s_tready, 1);

    // 6: mid-packet reset
    log_q.delete();
    for (int k = 0; k < 8; k++) begin
      b.d = {seq_m, 16'(k)}; b.keep = 4'hF; b.last = (k == 7);
      exp_q.push_back(b);
    end
    h0 = hs_cnt;
    mode = 1'b0;
    pkt_len = 16'd8;
    start = 1'b1;
    for (int i = 0; i < 50 && hs_cnt < h0 + 2; i++) begin
      @(posedge clock); #1;
    end
    check("t6_two_beats", hs_cnt - h0, 2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_dropped", m_tvalid, 0);
    check("t6_busy_dropped", busy, 0);
    exp_q.delete();
    fifo_m.delete();
    seq_m = '0;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6_tready_low", s_tready, 0);
    repeat (3) @(posedge clock);
    #1;
    launch(1'b0, 1, 1'b0, 1'b0);
    check("t6_seq_cleared", (log_q.size() == 1) ? log_q[0] : 32'hFFFF_FFFF, 32'h0000_0000);

    // len 0 with start held high: one done, no beats, no relaunch
    launch(1'b0, 0, 1'b1, 1'b0);
    check("t6_len0_beats", log_q.size(), 0);
    d0 = done_cnt;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (busy) busy_seen++;
    end
    check("t6_no_relaunch_busy", busy_seen, 0);
    check("t6_no_relaunch_done", done_cnt - d0, 0);
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    launch(1'b0, 2, 1'b0, 1'b0);
    check("t6_seq_after_len0", (log_q.size() == 2) ? log_q[1] : 32'hFFFF_FFFF, 32'h0002_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
